// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the MEM-stage BRAM access unit.
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2
    } size_t;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

    function automatic logic [3:0] store_be(input size_t sz, input logic [1:0] off);
        case (sz)
            SZ_WORD: return BE_WORD;
            SZ_HALF: return off[1] ? BE_HALF_HI : BE_HALF_LO;
            default: return BE_BYTE0 << off;
        endcase
    endfunction

    // Sub-word store data is replicated across all lanes; the byte enables pick the lane.
    function automatic logic [31:0] store_lanes(input size_t sz, input logic [31:0] wd);
        case (sz)
            SZ_WORD: return wd;
            SZ_HALF: return {2{wd[15:0]}};
            default: return {4{wd[7:0]}};
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Selects the addressed byte/half lane of a BRAM read word and sign- or zero-extends it.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  size_t       size,
    input  logic        zero_ext,
    output logic [31:0] result
);

    logic [15:0] half_v;
    logic [7:0]  byte_v;

    always_comb begin
        half_v = addr[1] ? rdata[31:16] : rdata[15:0];
        case (addr)
            2'd0:    byte_v = rdata[7:0];
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            default: byte_v = rdata[31:24];
        endcase
        case (size)
            SZ_HALF: result = {{16{~zero_ext & half_v[15]}}, half_v};
            SZ_BYTE: result = {{24{~zero_ext & byte_v[7]}}, byte_v};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for the word-wide data BRAM: issues loads/stores, stalls for read latency,
// and returns aligned, extended load data.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [31:0]       EX_MEM_Address,
    input  logic [31:0]       EX_MEM_WriteData,
    input  logic              EX_MEM_MemRead,
    input  logic              EX_MEM_MemWrite,
    input  logic              EX_MEM_HalfControl,
    input  logic              EX_MEM_ByteControl,
    input  logic              EX_MEM_Unsigned,
    output logic              MEM_Stall,
    output logic [31:0]       MEM_LoadData,
    output logic              MEM_LoadValid,
    output logic              MEM_MisalignErr,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [31:0]       Mem_WData,
    output logic [3:0]        Mem_WE,
    output logic              Mem_En,
    input  logic [31:0]       Mem_RData
);

    localparam int unsigned CNT_W = $clog2(READ_LATENCY + 1);

    state_t           state;
    size_t            size_q;
    size_t            req_size;
    logic [1:0]       off_q;
    logic             zero_ext_q;
    logic             is_load_q;
    logic [CNT_W-1:0] cnt;
    logic             req;
    logic             aligned;
    logic             accept;
    logic [31:0]      align_data;
    logic             unused_addr_hi;

    assign unused_addr_hi = ^EX_MEM_Address[31:ADDR_W+2];

    // Stall is masked by reset so a request held during reset cannot freeze the pipeline.
    always_comb begin
        req = EX_MEM_MemRead ^ EX_MEM_MemWrite;
        if (EX_MEM_HalfControl)
            req_size = SZ_HALF;
        else if (EX_MEM_ByteControl)
            req_size = SZ_BYTE;
        else
            req_size = SZ_WORD;
        case (req_size)
            SZ_WORD: aligned = (EX_MEM_Address[1:0] == 2'b00);
            SZ_HALF: aligned = ~EX_MEM_Address[0];
            default: aligned = 1'b1;
        endcase
        accept    = Rst_n && (state == IDLE) && req && aligned;
        MEM_Stall = accept || (state == ISSUE && is_load_q) || (state == WAIT);
    end

    mem_lane_align u_lane_align (
        .rdata    (Mem_RData),
        .addr     (off_q),
        .size     (size_q),
        .zero_ext (zero_ext_q),
        .result   (align_data)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state           <= IDLE;
            size_q          <= SZ_WORD;
            off_q           <= '0;
            zero_ext_q      <= 1'b0;
            is_load_q       <= 1'b0;
            cnt             <= '0;
            MEM_LoadData    <= '0;
            MEM_LoadValid   <= 1'b0;
            MEM_MisalignErr <= 1'b0;
            Mem_Addr        <= '0;
            Mem_WData       <= '0;
            Mem_WE          <= '0;
            Mem_En          <= 1'b0;
        end else begin
            Mem_En          <= 1'b0;
            Mem_WE          <= '0;
            MEM_LoadValid   <= 1'b0;
            MEM_MisalignErr <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= ISSUE;
                        Mem_En     <= 1'b1;
                        Mem_Addr   <= EX_MEM_Address[ADDR_W+1:2];
                        off_q      <= EX_MEM_Address[1:0];
                        size_q     <= req_size;
                        zero_ext_q <= EX_MEM_Unsigned;
                        is_load_q  <= EX_MEM_MemRead;
                        if (EX_MEM_MemWrite) begin
                            Mem_WE    <= store_be(req_size, EX_MEM_Address[1:0]);
                            Mem_WData <= store_lanes(req_size, EX_MEM_WriteData);
                        end
                    end else if (EX_MEM_MemRead || EX_MEM_MemWrite) begin
                        MEM_MisalignErr <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (is_load_q) begin
                        state <= WAIT;
                        cnt   <= CNT_W'(READ_LATENCY - 1);
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        MEM_LoadData  <= align_data;
                        MEM_LoadValid <= 1'b1;
                        state         <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised bench for mem_access_unit: two instances (read latency 1 and 3) share the request
// stream and are checked against a byte-addressed reference memory and a per-cycle timeline model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        half_ctl = 1'b0;
    logic        byte_ctl = 1'b0;
    logic        unsigned_ctl = 1'b0;

    logic        stall1, valid1, err1, en1;
    logic [31:0] ld1, wdata1;
    logic [9:0]  addr1;
    logic [3:0]  we1;
    logic [31:0] rdata1;

    logic        stall3, valid3, err3, en3;
    logic [31:0] ld3, wdata3;
    logic [9:0]  addr3;
    logic [3:0]  we3;
    logic [31:0] rdata3;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  ref_mem [0:4095];
    logic [31:0] bram1 [0:1023];
    logic [31:0] bram3 [0:1023];
    logic [31:0] pipe3 [0:2];
    logic [31:0] last_ld1 = '0;
    logic [31:0] last_ld3 = '0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(10), .READ_LATENCY(1)) u_dut1 (
        .Clk(clk), .Rst_n(rst_n), .EX_MEM_Address(address), .EX_MEM_WriteData(write_data),
        .EX_MEM_MemRead(mem_read), .EX_MEM_MemWrite(mem_write), .EX_MEM_HalfControl(half_ctl),
        .EX_MEM_ByteControl(byte_ctl), .EX_MEM_Unsigned(unsigned_ctl), .MEM_Stall(stall1),
        .MEM_LoadData(ld1), .MEM_LoadValid(valid1), .MEM_MisalignErr(err1), .Mem_Addr(addr1),
        .Mem_WData(wdata1), .Mem_WE(we1), .Mem_En(en1), .Mem_RData(rdata1)
    );

    mem_access_unit #(.ADDR_W(10), .READ_LATENCY(3)) u_dut3 (
        .Clk(clk), .Rst_n(rst_n), .EX_MEM_Address(address), .EX_MEM_WriteData(write_data),
        .EX_MEM_MemRead(mem_read), .EX_MEM_MemWrite(mem_write), .EX_MEM_HalfControl(half_ctl),
        .EX_MEM_ByteControl(byte_ctl), .EX_MEM_Unsigned(unsigned_ctl), .MEM_Stall(stall3),
        .MEM_LoadData(ld3), .MEM_LoadValid(valid3), .MEM_MisalignErr(err3), .Mem_Addr(addr3),
        .Mem_WData(wdata3), .Mem_WE(we3), .Mem_En(en3), .Mem_RData(rdata3)
    );

    // BRAM models: read data is valid only in the latency slot, random noise otherwise.
    always @(posedge clk) begin
        if (en1) begin
            for (int i = 0; i < 4; i++)
                if (we1[i]) bram1[addr1][8*i +: 8] <= wdata1[8*i +: 8];
            rdata1 <= bram1[addr1];
        end else begin
            rdata1 <= $urandom;
        end
    end

    always @(posedge clk) begin
        if (en3) begin
            for (int i = 0; i < 4; i++)
                if (we3[i]) bram3[addr3][8*i +: 8] <= wdata3[8*i +: 8];
            pipe3[0] <= bram3[addr3];
        end else begin
            pipe3[0] <= $urandom;
        end
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign rdata3 = pipe3[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // kind: 0 idle, 1 accepted load, 2 accepted store, 3 rejected request; k = cycles since presentation.
    function automatic logic [31:0] exp_ctl(input int kind, input int lat, input int k, input logic [3:0] we);
        logic s, e, v, r;
        logic [3:0] w;
        s = 1'b0; e = 1'b0; v = 1'b0; r = 1'b0; w = '0;
        case (kind)
            1: begin s = (k <= lat + 1); e = (k == 1); v = (k == lat + 2); end
            2: begin s = (k == 0); e = (k == 1); w = (k == 1) ? we : 4'b0000; end
            3: r = (k == 1);
            default: ;
        endcase
        return {24'd0, s, e, v, r, w};
    endfunction

    task automatic do_op(input logic rd, input logic wr, input logic hf, input logic by,
                         input logic un, input logic [31:0] a, input logic [31:0] wd);
        int          kind;
        int          n;
        int          base;
        logic [3:0]  we_e;
        logic [31:0] wd_e;
        logic [31:0] ld_e;
        n    = hf ? 2 : (by ? 1 : 4);
        base = int'(a[11:0]);
        if (rd && wr)
            kind = 3;
        else if (!rd && !wr)
            kind = 0;
        else if ((n == 4 && a[1:0] != 2'b00) || (n == 2 && a[0]))
            kind = 3;
        else
            kind = rd ? 1 : 2;
        we_e = 4'(((1 << n) - 1) << a[1:0]);
        for (int i = 0; i < 4; i++)
            wd_e[8*i +: 8] = wd[8*(i % n) +: 8];
        ld_e = '0;
        if (kind == 1) begin
            for (int i = 0; i < n; i++)
                ld_e[8*i +: 8] = ref_mem[base + i];
            if (!un && n < 4 && ld_e[8*n-1])
                for (int i = n; i < 4; i++)
                    ld_e[8*i +: 8] = 8'hFF;
        end
        if (kind == 2)
            for (int i = 0; i < n; i++)
                ref_mem[base + i] = wd[8*i +: 8];

        address = a; write_data = wd; mem_read = rd; mem_write = wr;
        half_ctl = hf; byte_ctl = by; unsigned_ctl = un;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("ctl_lat1", {24'd0, stall1, en1, valid1, err1, we1}, exp_ctl(kind, 1, k, we_e));
            check("ctl_lat3", {24'd0, stall3, en3, valid3, err3, we3}, exp_ctl(kind, 3, k, we_e));
            check("ld_lat1", ld1, (kind == 1 && k >= 3) ? ld_e : last_ld1);
            check("ld_lat3", ld3, (kind == 1 && k >= 5) ? ld_e : last_ld3);
            if (k == 1 && (kind == 1 || kind == 2)) begin
                check("addr_lat1", {22'd0, addr1}, {22'd0, a[11:2]});
                check("addr_lat3", {22'd0, addr3}, {22'd0, a[11:2]});
            end
            if (k == 1 && kind == 2) begin
                check("wdata_lat1", wdata1, wd_e);
                check("wdata_lat3", wdata3, wd_e);
            end
            @(posedge clk);
            #1;
            if (k == 0) begin
                mem_read = 1'b0; mem_write = 1'b0;
                address = $urandom; write_data = $urandom;
            end
        end
        if (kind == 1) begin
            last_ld1 = ld_e;
            last_ld3 = ld_e;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl1"}, {24'd0, stall1, en1, valid1, err1, we1}, 32'd0);
        check({tag, "_ctl3"}, {24'd0, stall3, en3, valid3, err3, we3}, 32'd0);
        check({tag, "_ld1"}, ld1, 32'd0);
        check({tag, "_ld3"}, ld3, 32'd0);
        check({tag, "_bus1"}, {22'd0, addr1} | wdata1, 32'd0);
        check({tag, "_bus3"}, {22'd0, addr3} | wdata3, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] r;
        int          n;
        logic        hf, by;

        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
        for (int i = 0; i < 1024; i++) begin
            bram1[i] = '0;
            bram3[i] = '0;
        end

        #12;
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed cases
        do_op(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h13, 32'h0000_00A5);
        do_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
        do_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'hDEAD_BEEF);
        do_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h8001_7F80);
        do_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        do_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0);
        do_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h2, 32'h0);
        do_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h2, 32'h0);
        do_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h6, 32'h0);
        do_op(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1, 32'h1234);
        do_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0);
        do_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_F010, 32'h0);

        // Reset in the middle of a load, with the request still presented
        address = 32'h10; mem_read = 1'b1; half_ctl = 1'b0; byte_ctl = 1'b0; unsigned_ctl = 1'b0;
        @(posedge clk); #1;
        mem_read = 1'b0;
        @(posedge clk); #1;
        mem_read = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_wait");
        last_ld1 = '0;
        last_ld3 = '0;
        @(posedge clk); #1;
        check_reset_outputs("rst_held");
        rst_n = 1'b1;
        do_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0);

        // Random traffic
        for (int t = 0; t < 160; t++) begin
            r  = $urandom_range(0, 9);
            n  = $urandom_range(0, 2);
            hf = (n == 1);
            by = (n == 2) || (n == 1 && $urandom_range(0, 1) == 1);
            a  = $urandom_range(0, 63);
            if ($urandom_range(0, 3) != 0) a = hf ? (a & ~32'd1) : (by ? a : (a & ~32'd3));
            if ($urandom_range(0, 1) == 1) a = a | ($urandom & 32'hFFFF_F000);
            do_op(r <= 3 || r == 8, (r >= 4 && r <= 8), hf, by, $urandom_range(0, 1) == 1, a, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
